// File: rtl/mips32_fetch_queue_if.sv
// mips32_fetch_queue_if: fetch front-end signals (imem request/response, redirect, halt, ID handshake)
interface mips32_fetch_queue_if #(parameter int ADDR_W = 10);
  logic              imem_req_valid;
  logic [ADDR_W-1:0] imem_req_addr;
  logic              imem_req_ready;
  logic              imem_rsp_valid;
  logic [31:0]       imem_rsp_data;
  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic              halt;
  logic              if_valid;
  logic [31:0]       if_ir;
  logic [31:0]       if_npc;
  logic              if_ready;
  modport master (
    output imem_req_valid, imem_req_addr, if_valid, if_ir, if_npc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, halt, if_ready
  );
  modport slave (
    input  imem_req_valid, imem_req_addr, if_valid, if_ir, if_npc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, halt, if_ready
  );
endinterface

// File: rtl/mips32_fetch_queue.sv
// mips32_fetch_queue: credit-limited imem fetch queue feeding ID; optional counters under MIPS32_FETCH_PERF_EN
module mips32_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter int          ADDR_W   = 10,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic clk1,
  input  logic reset,
  mips32_fetch_queue_if.master bus
`ifdef MIPS32_FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_flushed
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [31:0]   pc;
  logic [CW-1:0] count, inflight, drop;
  logic [AW-1:0] head, tail, tag_rd, tag_wr;
  logic [31:0]   q_ir    [DEPTH];
  logic [31:0]   q_npc   [DEPTH];
  logic [31:0]   tag_mem [DEPTH];
  logic [CW:0]   credit;
  logic          req_fire, rsp, push, pop, redir;
  assign bus.imem_req_valid = !reset && !bus.halt && !bus.redirect_valid && (credit < (CW+1)'(DEPTH));
  assign bus.imem_req_addr  = pc[ADDR_W-1:0];
  assign bus.if_valid       = !reset && count != '0;
  assign bus.if_ir          = q_ir[head];
  assign bus.if_npc         = q_npc[head];
  // handshake qualification: redirect discards this cycle's response and pop
  always_comb begin
    redir    = bus.redirect_valid;
    credit   = {1'b0, inflight} + {1'b0, count};
    req_fire = bus.imem_req_valid && bus.imem_req_ready;
    rsp      = bus.imem_rsp_valid;
    push     = rsp && drop == '0 && !redir;
    pop      = bus.if_valid && bus.if_ready && !redir;
  end
  // control state; every response retires a tag so the tag FIFO stays aligned across flushes
  always_ff @(posedge clk1) begin
    if (reset) begin
      pc       <= RESET_PC;
      count    <= '0;
      inflight <= '0;
      drop     <= '0;
      head     <= '0;
      tail     <= '0;
      tag_rd   <= '0;
      tag_wr   <= '0;
    end else begin
      pc       <= redir ? bus.redirect_pc : req_fire ? pc + 32'd1 : pc;
      inflight <= inflight + CW'(req_fire) - CW'(rsp);
      drop     <= redir ? inflight - CW'(rsp) : drop - CW'(rsp && drop != '0);
      count    <= redir ? '0 : count + CW'(push) - CW'(pop);
      head     <= redir ? tail : head + AW'(pop);
      tail     <= tail + AW'(push);
      tag_wr   <= tag_wr + AW'(req_fire);
      tag_rd   <= tag_rd + AW'(rsp);
    end
  end
  // storage: tag FIFO holds NPC per outstanding request, queue holds {ir, npc}
  always_ff @(posedge clk1) begin
    if (req_fire) tag_mem[tag_wr] <= pc + 32'd1;
    if (push) begin
      q_ir[tail]  <= bus.imem_rsp_data;
      q_npc[tail] <= tag_mem[tag_rd];
    end
  end
  // a response with nothing outstanding means the memory broke the protocol
  always_ff @(posedge clk1) begin
    if (!reset && bus.imem_rsp_valid) assert (inflight != '0) else $error("imem response with no request outstanding");
  end
`ifdef MIPS32_FETCH_PERF_EN
  // fetched counts queue writes; flushed counts entries cleared plus responses discarded after a redirect
  always_ff @(posedge clk1) begin
    if (reset) begin
      perf_fetched <= '0;
      perf_flushed <= '0;
    end else begin
      perf_fetched <= perf_fetched + 32'(push);
      perf_flushed <= perf_flushed + (redir ? 32'(count) : 32'd0) + 32'(rsp && (redir || drop != '0));
    end
  end
`endif
endmodule

// File: tb/tb_mips32_fetch_queue.sv
// tb_mips32_fetch_queue: directed checks of fetch, backpressure, redirect, halt, wrap and perf counters
module tb_mips32_fetch_queue;
  logic clk1 = 1'b0;
  logic reset;
  int   lat = 1;
  int   checks = 0;
  int   passed = 0;
  int   fires;
  int   bad;
  logic [3:0] pv;
  logic [9:0] pa [4];
`ifdef MIPS32_FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_flushed;
`endif
  mips32_fetch_queue_if #(.ADDR_W(10)) bus ();
  mips32_fetch_queue #(.DEPTH(4), .ADDR_W(10), .RESET_PC(32'h0)) dut (
    .clk1(clk1),
    .reset(reset),
    .bus(bus)
`ifdef MIPS32_FETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_flushed(perf_flushed)
`endif
  );
  always #5 clk1 = ~clk1;
  function automatic logic [31:0] word_at(input logic [9:0] a);
    return {12'hC0D, 10'h000, a};
  endfunction
  // memory model: fixed latency pipeline, cleared while reset is held
  always_ff @(posedge clk1) begin
    if (reset) pv <= '0;
    else pv <= {pv[2:0], bus.imem_req_valid & bus.imem_req_ready};
    pa[0] <= bus.imem_req_addr;
    pa[1] <= pa[0];
    pa[2] <= pa[1];
    pa[3] <= pa[2];
  end
  assign bus.imem_rsp_valid = pv[2'(lat-1)];
  assign bus.imem_rsp_data  = word_at(pa[2'(lat-1)]);
  task automatic tick;
    @(posedge clk1);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask
  task automatic restart(input int l, input logic rdy);
    reset = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.halt = 1'b0;
    bus.if_ready = rdy;
    bus.imem_req_ready = 1'b1;
    lat = l;
    repeat (4) tick;
    reset = 1'b0;
    #1;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end
  initial begin
    reset = 1'b1;
    bus.imem_req_ready = 1'b1;
    bus.if_ready = 1'b1;
    bus.halt = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'h0;
    tick;
    tick;
    #1;
    chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    chk("rst_if_valid", 32'(bus.if_valid), 32'd0);
    chk("rst_count", 32'(dut.count), 32'd0);
    reset = 1'b0;
    #1;
    chk("t1_req_c0", 32'(bus.imem_req_valid), 32'd1);
    chk("t1_addr_c0", 32'(bus.imem_req_addr), 32'd0);
    tick; #1;
    chk("t1_ifv_c1", 32'(bus.if_valid), 32'd0);
    chk("t1_addr_c1", 32'(bus.imem_req_addr), 32'd1);
    tick; #1;
    chk("t1_ifv_c2", 32'(bus.if_valid), 32'd1);
    chk("t1_ir_c2", bus.if_ir, word_at(10'd0));
    chk("t1_npc_c2", bus.if_npc, 32'd1);
    chk("t1_addr_c2", 32'(bus.imem_req_addr), 32'd2);
    tick; #1;
    chk("t1_ir_c3", bus.if_ir, word_at(10'd1));
    chk("t1_npc_c3", bus.if_npc, 32'd2);
    tick; #1;
    chk("t1_ir_c4", bus.if_ir, word_at(10'd2));
    chk("t1_npc_c4", bus.if_npc, 32'd3);
    reset = 1'b1;
    #1;
    chk("t2_rst_ifv", 32'(bus.if_valid), 32'd0);
    chk("t2_rst_req", 32'(bus.imem_req_valid), 32'd0);
    restart(1, 1'b0);
    fires = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.imem_req_valid && bus.imem_req_ready) fires++;
      tick; #1;
    end
    chk("t2_fires", 32'(fires), 32'd4);
    chk("t2_req_stop", 32'(bus.imem_req_valid), 32'd0);
    chk("t2_count", 32'(dut.count), 32'd4);
    chk("t2_hold_ir", bus.if_ir, word_at(10'd0));
    bus.if_ready = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("t2_drain_ir", bus.if_ir, word_at(10'(i)));
      chk("t2_drain_npc", bus.if_npc, 32'(i + 1));
      tick; #1;
    end
    restart(3, 1'b0);
    tick;
    bus.imem_req_ready = 1'b0;
    #1;
    chk("t3_addr_c1", 32'(bus.imem_req_addr), 32'd1);
    tick;
    bus.imem_req_ready = 1'b1;
    #1;
    tick; #1;
    chk("t3_addr_c3", 32'(bus.imem_req_addr), 32'd2);
    tick;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h20;
    #1;
    chk("t3_pre_inflight", 32'(dut.inflight), 32'd2);
    chk("t3_pre_count", 32'(dut.count), 32'd1);
    chk("t3_pre_ir", bus.if_ir, word_at(10'd0));
    chk("t3_redir_noreq", 32'(bus.imem_req_valid), 32'd0);
    tick;
    bus.redirect_valid = 1'b0;
    #1;
    chk("t3_flush_ifv", 32'(bus.if_valid), 32'd0);
    chk("t3_drop", 32'(dut.drop), 32'd2);
    chk("t3_new_req", 32'(bus.imem_req_valid), 32'd1);
    chk("t3_new_addr", 32'(bus.imem_req_addr), 32'h20);
    tick; #1;
    tick; #1;
    tick; #1;
    chk("t3_c8_ifv", 32'(bus.if_valid), 32'd0);
    chk("t3_c8_drop", 32'(dut.drop), 32'd0);
    tick; #1;
    chk("t3_c9_ifv", 32'(bus.if_valid), 32'd1);
    chk("t3_c9_ir", bus.if_ir, word_at(10'h20));
    chk("t3_c9_npc", bus.if_npc, 32'h21);
    restart(1, 1'b1);
    tick; #1;
    tick;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h40;
    #1;
    chk("t4_rsp_same", 32'(bus.imem_rsp_valid), 32'd1);
    chk("t4_ir_same", bus.if_ir, word_at(10'd0));
    chk("t4_noreq", 32'(bus.imem_req_valid), 32'd0);
    tick;
    bus.redirect_valid = 1'b0;
    #1;
    chk("t4_c3_ifv", 32'(bus.if_valid), 32'd0);
    chk("t4_c3_addr", 32'(bus.imem_req_addr), 32'h40);
    tick; #1;
    chk("t4_c4_ifv", 32'(bus.if_valid), 32'd0);
    tick; #1;
    chk("t4_c5_ir", bus.if_ir, word_at(10'h40));
    chk("t4_c5_npc", bus.if_npc, 32'h41);
    restart(3, 1'b1);
    tick; #1;
    tick;
    bus.halt = 1'b1;
    #1;
    chk("t5_halt_noreq", 32'(bus.imem_req_valid), 32'd0);
    chk("t5_inflight", 32'(dut.inflight), 32'd2);
    tick; #1;
    tick; #1;
    chk("t5_ir0", bus.if_ir, word_at(10'd0));
    chk("t5_npc0", bus.if_npc, 32'd1);
    tick; #1;
    chk("t5_ir1", bus.if_ir, word_at(10'd1));
    chk("t5_npc1", bus.if_npc, 32'd2);
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      tick; #1;
      if (bus.if_valid || bus.imem_req_valid) bad++;
    end
    chk("t5_idle", 32'(bad), 32'd0);
    restart(1, 1'b1);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFFF;
    #1;
    chk("t6_noreq", 32'(bus.imem_req_valid), 32'd0);
    tick;
    bus.redirect_valid = 1'b0;
    #1;
    chk("t6_addr_top", 32'(bus.imem_req_addr), 32'h3FF);
    tick; #1;
    chk("t6_addr_wrap", 32'(bus.imem_req_addr), 32'd0);
    tick; #1;
    chk("t6_ir_top", bus.if_ir, word_at(10'h3FF));
    chk("t6_npc_wrap", bus.if_npc, 32'd0);
    tick; #1;
    chk("t6_ir_zero", bus.if_ir, word_at(10'd0));
    chk("t6_npc_one", bus.if_npc, 32'd1);
`ifdef MIPS32_FETCH_PERF_EN
    restart(1, 1'b1);
    repeat (6) tick;
    bus.if_ready = 1'b0;
    tick;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h80;
    #1;
    chk("t7_count", 32'(dut.count), 32'd2);
    chk("t7_fetched_pre", perf_fetched, 32'd6);
    chk("t7_flushed_pre", perf_flushed, 32'd0);
    tick;
    bus.redirect_valid = 1'b0;
    #1;
    chk("t7_fetched", perf_fetched, 32'd6);
    chk("t7_flushed", perf_flushed, 32'd3);
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
